tile_rom_responder: RTL
=======================

TILE_ROM_RESPONDER -- requirements
Module: tile_rom_responder

Interface
REQ-001 Parameter BANK_A, default 7'h00: upper SDRAM address bits for client A.
REQ-002 Parameter BANK_B, default 7'h01: upper SDRAM address bits for client B.
REQ-003 CLK_32M  in  1  sole clock; all logic on rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 a_req  in  1  client A fetch strobe, one-cycle pulse.
REQ-006 a_addr  in  18  client A 16-bit-word ROM address, sampled with a_req.
REQ-007 a_data  out  32  client A returned tile row.
REQ-008 a_rdy  out  1  client A data-valid, one-cycle pulse.
REQ-009 b_req, b_addr, b_data, b_rdy  as REQ-005..008 for client B.
REQ-010 mem_req  out  1  SDRAM read request, level, held until mem_rdy.
REQ-011 mem_addr  out  25  SDRAM word address, stable while mem_req high.
REQ-012 mem_data  in  32  SDRAM read data, valid with mem_rdy.
REQ-013 mem_rdy  in  1  SDRAM completion pulse.
REQ-014 rom_flush  in  1  cache invalidate strobe (see Configuration).

Function
REQ-015 Each client has one pending slot (valid + 18-bit addr); a req loads it, later req before service overwrites addr (latest wins).
REQ-016 FSM states: IDLE, BUSY, DONE.
REQ-017 IDLE: if any pending slot valid, grant one, clear its slot, drive mem_req=1, mem_addr={BANK_x, addr}, go BUSY next cycle.
REQ-018 Arbitration: both pending -> grant client not granted last; after reset A wins first tie.
REQ-019 BUSY: hold mem_req and mem_addr; on mem_rdy capture mem_data, deassert mem_req same edge, go DONE.
REQ-020 DONE: drive granted client's x_data with captured word and pulse x_rdy for exactly one cycle; return IDLE.
REQ-021 Latency: x_rdy asserted the cycle after mem_rdy; uncontended req -> mem_req asserted two cycles after req.
REQ-022 x_data holds last delivered value between rdy pulses.
REQ-023 A req arriving for the client in BUSY/DONE goes to pending; in-flight result still delivered.
REQ-024 a_req and b_req simultaneous: both slots load; served in arbitration order.
REQ-025 req coinciding with its own slot being granted: slot re-loads with new address, not lost.
REQ-026 mem_rdy outside BUSY ignored.
REQ-027 At most one outstanding SDRAM request at any time.

Reset
REQ-028 RESET_N low: FSM to IDLE, mem_req=0, mem_addr=0, a_rdy=b_rdy=0, a_data=b_data=0, slots invalid, last-grant=B.
REQ-029 Reset mid-BUSY drops mem_req immediately; a subsequent stale mem_rdy while IDLE is ignored.

Configuration
REQ-030 Macro TILE_ROM_CACHE_EN: defined -> per-client single-entry cache (tag 18 bits, data 32, valid), filled on each DONE delivery.
REQ-031 With cache: req whose addr equals valid tag, while that client has no in-flight or pending request, pulses x_rdy next cycle with cached data and issues no mem_req; otherwise handled as miss.
REQ-032 With cache: rom_flush clears both valid bits; flush coinciding with fill leaves entry invalid.
REQ-033 Without macro: no cache storage, every req goes to SDRAM, rom_flush ignored.

Verification
REQ-034 a_req addr 18'h01234, mem_rdy 5 cycles after mem_req with 32'hDEADBEEF -> mem_addr 25'h0001234, a_rdy one cycle after mem_rdy, a_data DEADBEEF.
REQ-035 a_req+b_req same cycle (A 18'h00010, B 18'h00020) -> mem_addr 25'h0000010 first then 25'h0040020; a_rdy precedes b_rdy; repeat tie -> B first.
REQ-036 During A BUSY issue a_req 18'h00100 then 18'h00200 -> first result delivered, then only 18'h00200 fetched.
REQ-037 Assert RESET_N low mid-BUSY, then mem_rdy pulse -> mem_req low immediately, no x_rdy, FSM IDLE.
REQ-038 TILE_ROM_CACHE_EN: repeat a_req same addr after delivery -> a_rdy next cycle, mem_req stays 0; after rom_flush same addr -> SDRAM fetch; without macro -> always fetched.

Source files
------------

// File: rtl/tile_rom_responder.sv
// tile_rom_responder: two-client tile ROM fetch arbiter in front of a single SDRAM read port.
//   Optional build macro TILE_ROM_CACHE_EN adds a single-entry cache per client.
//   Ports:
//     CLK_32M, RESET_N            clock, async active-low reset
//     a_req/a_addr -> a_data/a_rdy client A fetch strobe + 18-bit address, returned row + valid pulse
//     b_req/b_addr -> b_data/b_rdy client B, same as A
//     mem_req/mem_addr            SDRAM read request level + 25-bit word address
//     mem_data/mem_rdy            SDRAM read data + completion pulse
//     rom_flush                   cache invalidate strobe (ignored without the cache)
module tile_rom_responder #(
    parameter logic [6:0] BANK_A = 7'h00,
    parameter logic [6:0] BANK_B = 7'h01
) (
    input  logic        CLK_32M,
    input  logic        RESET_N,
    input  logic        a_req,
    input  logic [17:0] a_addr,
    output logic [31:0] a_data,
    output logic        a_rdy,
    input  logic        b_req,
    input  logic [17:0] b_addr,
    output logic [31:0] b_data,
    output logic        b_rdy,
    output logic        mem_req,
    output logic [24:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_rdy,
    input  logic        rom_flush
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        a_pend_q, a_pend_d, b_pend_q, b_pend_d;
    logic [17:0] a_paddr_q, a_paddr_d, b_paddr_q, b_paddr_d;
    logic        mem_req_q, mem_req_d;
    logic [24:0] mem_addr_q, mem_addr_d;
    logic [31:0] a_data_q, a_data_d, b_data_q, b_data_d;
    logic        a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
    logic        take, gnt_b, a_fin, b_fin, a_hit, b_hit;
    logic [31:0] a_cd_q, b_cd_q;
    // grant_q/last_q: 0 = client A, 1 = client B
    assign take  = (state_q == IDLE) && (a_pend_q || b_pend_q);
    assign gnt_b = b_pend_q && (!a_pend_q || !last_q);
    assign a_fin = (state_q == BUSY) && mem_rdy && !grant_q;
    assign b_fin = (state_q == BUSY) && mem_rdy && grant_q;
`ifdef TILE_ROM_CACHE_EN
    logic        a_cv_q, a_cv_d, b_cv_q, b_cv_d;
    logic [17:0] a_tag_q, a_tag_d, b_tag_q, b_tag_d;
    logic [31:0] a_cd_d, b_cd_d;
    // A hit is only served when nothing older for that client could still be delivered after it.
    assign a_hit = a_req && a_cv_q && (a_tag_q == a_addr) && !a_pend_q && !(state_q != IDLE && !grant_q);
    assign b_hit = b_req && b_cv_q && (b_tag_q == b_addr) && !b_pend_q && !(state_q != IDLE && grant_q);
    always_comb begin
        a_cv_d  = !rom_flush && (a_fin || a_cv_q);
        b_cv_d  = !rom_flush && (b_fin || b_cv_q);
        a_tag_d = a_fin ? mem_addr_q[17:0] : a_tag_q;
        b_tag_d = b_fin ? mem_addr_q[17:0] : b_tag_q;
        a_cd_d  = a_fin ? mem_data : a_cd_q;
        b_cd_d  = b_fin ? mem_data : b_cd_q;
    end
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            a_cv_q  <= 1'b0;
            b_cv_q  <= 1'b0;
            a_tag_q <= '0;
            b_tag_q <= '0;
            a_cd_q  <= '0;
            b_cd_q  <= '0;
        end else begin
            a_cv_q  <= a_cv_d;
            b_cv_q  <= b_cv_d;
            a_tag_q <= a_tag_d;
            b_tag_q <= b_tag_d;
            a_cd_q  <= a_cd_d;
            b_cd_q  <= b_cd_d;
        end
    end
`else
    logic unused_flush;
    assign unused_flush = rom_flush;
    assign a_hit  = 1'b0;
    assign b_hit  = 1'b0;
    assign a_cd_q = '0;
    assign b_cd_q = '0;
`endif
    always_comb begin
        state_d    = (state_q == IDLE) ? (take ? BUSY : IDLE) :
                     (state_q == BUSY) ? (mem_rdy ? DONE : BUSY) : IDLE;
        grant_d    = take ? gnt_b : grant_q;
        last_d     = take ? gnt_b : last_q;
        // A new request re-arms the slot even in the cycle its old contents are granted.
        a_pend_d   = (a_req && !a_hit) || (a_pend_q && !(take && !gnt_b));
        b_pend_d   = (b_req && !b_hit) || (b_pend_q && !(take && gnt_b));
        a_paddr_d  = a_req ? a_addr : a_paddr_q;
        b_paddr_d  = b_req ? b_addr : b_paddr_q;
        mem_req_d  = take || (mem_req_q && !(state_q == BUSY && mem_rdy));
        mem_addr_d = !take ? mem_addr_q : gnt_b ? {BANK_B, b_paddr_q} : {BANK_A, a_paddr_q};
        a_rdy_d    = a_hit || a_fin;
        b_rdy_d    = b_hit || b_fin;
        a_data_d   = a_hit ? a_cd_q : a_fin ? mem_data : a_data_q;
        b_data_d   = b_hit ? b_cd_q : b_fin ? mem_data : b_data_q;
    end
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            a_pend_q   <= 1'b0;
            b_pend_q   <= 1'b0;
            a_paddr_q  <= '0;
            b_paddr_q  <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            a_data_q   <= '0;
            b_data_q   <= '0;
            a_rdy_q    <= 1'b0;
            b_rdy_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            a_pend_q   <= a_pend_d;
            b_pend_q   <= b_pend_d;
            a_paddr_q  <= a_paddr_d;
            b_paddr_q  <= b_paddr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
            a_rdy_q    <= a_rdy_d;
            b_rdy_q    <= b_rdy_d;
        end
    end
    assign a_data   = a_data_q;
    assign b_data   = b_data_q;
    assign a_rdy    = a_rdy_q;
    assign b_rdy    = b_rdy_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
endmodule
